// File: rtl/mmb_to_mmv_pkg.sv
// Shared types for the mmb-to-mmv burst splitter.
package mmb_to_mmv_pkg;

  typedef enum logic [1:0] {
    st_idle  = 2'b00,
    st_write = 2'b01,
    st_read  = 2'b10
  } state_t;

endpackage

// File: rtl/mmb_to_mmv_if.sv
// Burst-side (mmb) and single-access-side (mmv) bus bundles.
interface mmb_if #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8,
  parameter int BWIDTH = 4
);
  logic [AWIDTH-1:0] s_addr;
  logic [BWIDTH-1:0] s_bcnt;
  logic              s_wreq;
  logic [DWIDTH-1:0] s_wdat;
  logic              s_rreq;
  logic [DWIDTH-1:0] s_rdat;
  logic              s_rval;
  logic              s_busy;

  modport master (
    output s_addr, s_bcnt, s_wreq, s_wdat, s_rreq,
    input  s_rdat, s_rval, s_busy
  );
  modport slave (
    input  s_addr, s_bcnt, s_wreq, s_wdat, s_rreq,
    output s_rdat, s_rval, s_busy
  );
endinterface

interface mmv_if #(
  parameter int AWIDTH = 8,
  parameter int DWIDTH = 8
);
  logic [AWIDTH-1:0] m_addr;
  logic              m_wreq;
  logic [DWIDTH-1:0] m_wdat;
  logic              m_rreq;
  logic [DWIDTH-1:0] m_rdat;
  logic              m_rval;
  logic              m_busy;

  modport master (
    output m_addr, m_wreq, m_wdat, m_rreq,
    input  m_rdat, m_rval, m_busy
  );
  modport slave (
    input  m_addr, m_wreq, m_wdat, m_rreq,
    output m_rdat, m_rval, m_busy
  );
endinterface

// File: rtl/mmb_to_mmv_acnt.sv
// Loadable address incrementer with beat down-counter and last-beat flag.
module mmb_to_mmv_acnt #(
  parameter int AWIDTH = 8,
  parameter int BWIDTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic [AWIDTH-1:0] load_addr_i,
  input  logic [BWIDTH:0]   load_cnt_i,
  input  logic              step_i,
  output logic [AWIDTH-1:0] addr_o,
  output logic              last_o
);

  logic [AWIDTH-1:0] addr_q, addr_d;
  logic [BWIDTH:0]   cnt_q, cnt_d;

  always_comb begin
    addr_d = addr_q;
    cnt_d  = cnt_q;
    if (load_i) begin
      addr_d = load_addr_i;
      cnt_d  = load_cnt_i;
    end else if (step_i) begin
      addr_d = addr_q + AWIDTH'(1);
      cnt_d  = cnt_q - (BWIDTH+1)'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      cnt_q  <= '0;
    end else begin
      addr_q <= addr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign addr_o = addr_q;
  assign last_o = (cnt_q == (BWIDTH+1)'(1));

endmodule

// File: rtl/mmb_to_mmv.sv
// Splits mmb bursts into single mmv accesses at incrementing addresses.
// Optional write-stall watchdog: define MMB_TO_MMV_WTIMEOUT_EN.
module mmb_to_mmv
  import mmb_to_mmv_pkg::*;
#(
  parameter int AWIDTH   = 8,
  parameter int DWIDTH   = 8,
  parameter int BWIDTH   = 4,
  parameter int WTIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  mmb_if.slave  s_bus,
  mmv_if.master m_bus
);

  state_t            state_q, state_d;
  logic              load, step, last;
  logic [AWIDTH-1:0] load_addr, addr_q;
  logic [BWIDTH:0]   load_cnt;
  logic [AWIDTH-1:0] m_addr;
  logic              m_wreq, m_rreq, s_busy;
  logic              w_accept, timeout;

  mmb_to_mmv_acnt #(
    .AWIDTH (AWIDTH),
    .BWIDTH (BWIDTH)
  ) u_acnt (
    .clk         (clk),
    .reset       (reset),
    .load_i      (load),
    .load_addr_i (load_addr),
    .load_cnt_i  (load_cnt),
    .step_i      (step),
    .addr_o      (addr_q),
    .last_o      (last)
  );

  assign w_accept = s_bus.s_wreq && !m_bus.m_busy;

`ifdef MMB_TO_MMV_WTIMEOUT_EN
  localparam int TW = $clog2(WTIMEOUT + 1);
  logic [TW-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = '0;
    if (state_q == st_write && !w_accept) begin
      stall_d = s_bus.s_wreq ? stall_q : stall_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) stall_q <= '0;
    else       stall_q <= stall_d;
  end

  assign timeout = (state_q == st_write) && !s_bus.s_wreq &&
                   (stall_q == TW'(WTIMEOUT - 1));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    step      = 1'b0;
    load_addr = s_bus.s_addr;
    load_cnt  = {1'b0, s_bus.s_bcnt};
    m_addr    = s_bus.s_addr;
    m_wreq    = 1'b0;
    m_rreq    = 1'b0;
    s_busy    = 1'b0;
    case (state_q)
      st_idle: begin
        if (s_bus.s_wreq) begin
          // Write has priority; a concurrent read waits behind s_busy.
          m_wreq = 1'b1;
          s_busy = m_bus.m_busy;
          if (w_accept) begin
            load      = 1'b1;
            load_addr = s_bus.s_addr + AWIDTH'(1);
            if (s_bus.s_bcnt != '0) state_d = st_write;
          end
        end else if (s_bus.s_rreq) begin
          load     = 1'b1;
          load_cnt = {1'b0, s_bus.s_bcnt} + (BWIDTH+1)'(1);
          state_d  = st_read;
        end
      end
      st_write: begin
        m_addr = addr_q;
        m_wreq = s_bus.s_wreq;
        s_busy = m_bus.m_busy;
        if (w_accept) begin
          step = 1'b1;
          if (last) state_d = st_idle;
        end else if (timeout) begin
          state_d = st_idle;
        end
      end
      st_read: begin
        m_addr = addr_q;
        m_rreq = 1'b1;
        s_busy = 1'b1;
        if (!m_bus.m_busy) begin
          step = 1'b1;
          if (last) state_d = st_idle;
        end
      end
      default: state_d = st_idle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= st_idle;
    else       state_q <= state_d;
  end

  assign m_bus.m_addr = m_addr;
  assign m_bus.m_wreq = m_wreq;
  assign m_bus.m_wdat = s_bus.s_wdat;
  assign m_bus.m_rreq = m_rreq;
  assign s_bus.s_busy = s_busy;
  assign s_bus.s_rdat = m_bus.m_rdat;
  assign s_bus.s_rval = m_bus.m_rval;

endmodule

// File: doc/mmb_to_mmv.md
Name: mmb_to_mmv

Overview:
Burst-to-single-access converter that sits downstream of a burst (mmb) master and drives a simple single-word memory-mapped (mmv) slave. A write burst becomes a run of consecutive single writes at incrementing addresses. A read burst becomes a run of consecutive single reads at incrementing addresses, with read data passed back in order. It pairs with the mmv-to-mmb stage, so register and memory slaves can hang off a burst fabric.

Parameters:
AWIDTH, 8, address width
DWIDTH, 8, data width
BWIDTH, 4, burst size field width; burst length = s_bcnt + 1 (1 .. 2**BWIDTH)
WTIMEOUT, 255, write-stall watchdog limit in clocks (used only with the optional feature)

Ports:
reset  in  1  asynchronous reset, active-high
clk  in  1  clock
s_addr  in  AWIDTH  burst start address, sampled on the first beat only
s_bcnt  in  BWIDTH  burst length minus one, sampled on the first beat only
s_wreq  in  1  write beat request
s_wdat  in  DWIDTH  write beat data
s_rreq  in  1  read burst request
s_rdat  out  DWIDTH  read data
s_rval  out  1  read data valid
s_busy  out  1  slave-side stall; a request is accepted when req && !s_busy
m_addr  out  AWIDTH  single-access address
m_wreq  out  1  single write request
m_wdat  out  DWIDTH  single write data
m_rreq  out  1  single read request
m_rdat  in  DWIDTH  read data from the mmv slave
m_rval  in  1  read data valid from the mmv slave
m_busy  in  1  mmv slave stall; an access is taken when req && !m_busy

Behaviour:
- Reset is asynchronous and active-high; clk is the only clock. Reset state: state = st_idle, address register = 0, beat counter = 0, m_wreq = 0, m_rreq = 0, s_busy = 0. s_rdat and s_rval are not registered.
- Read-return path: s_rdat = m_rdat and s_rval = m_rval, combinationally in every state. Latency is 0 cycles through this block.
- FSM states: st_idle, st_write, st_read.
- st_idle, write first beat:
  - m_wreq = s_wreq, m_addr = s_addr, m_wdat = s_wdat, s_busy = m_busy.
  - On accept (s_wreq && !m_busy): load addr_reg = s_addr + 1 and cnt = s_bcnt.
  - If s_bcnt == 0, stay in st_idle; otherwise go to st_write.
- st_write:
  - m_wreq = s_wreq, m_addr = addr_reg, m_wdat = s_wdat, s_busy = m_busy.
  - s_addr and s_bcnt are ignored.
  - Each accepted beat does addr_reg++ and cnt--. Accepting the beat while cnt == 1 returns the FSM to st_idle.
  - s_rreq is ignored here (not accepted, m_rreq = 0).
- st_idle, read request:
  - Taken when s_rreq && !s_wreq. Accepted in the same cycle regardless of m_busy; s_busy = 0.
  - Latch addr_reg = s_addr and cnt = s_bcnt + 1 (BWIDTH+1 bits); go to st_read.
- Simultaneous s_wreq and s_rreq in st_idle: write wins and the read stays pending at the master, because s_busy = m_busy is then shown for the write.
- st_read:
  - s_busy = 1; m_rreq = 1; m_addr = addr_reg.
  - Each cycle with !m_busy does addr_reg++ and cnt--. When the access with cnt == 1 is taken, go to st_idle.
  - New bursts are accepted once the last read is issued; outstanding read data keeps flowing through the return path.
- m_wreq and m_rreq are never high together.
- Address arithmetic is modulo 2**AWIDTH: 0xFF + 1 wraps to 0x00 with no error.
- Reset mid-burst: the FSM returns to st_idle immediately and the rest of the burst is dropped. Stale m_rval beats still pass to s_rval; the master side is reset together with this block.

Optional Feature:
MMB_TO_MMV_WTIMEOUT_EN
- Defined: a stall counter runs in st_write.
  - Cleared on every accepted beat; increments on cycles with !s_wreq.
  - When it reaches WTIMEOUT, the FSM drops the burst and goes to st_idle. The next s_wreq is then treated as a new first beat.
- Undefined: there is no counter, WTIMEOUT is unused, and st_write waits indefinitely for the remaining beats.

Decomposition:
- Package mmb_to_mmv_pkg holds the state enum type (st_idle = 2'b00, st_write = 2'b01, st_read = 2'b10).
- One sub-module is natural: mmb_to_mmv_acnt, the loadable address incrementer plus down-counter with a last-beat flag. It is shared by the write and read paths.

Test Plan:
1. Write burst, s_addr = 0x10, s_bcnt = 3, data A0..A3, m_busy = 0 -> m_wreq on 4 consecutive cycles at m_addr 0x10..0x13 with data A0..A3; FSM back to st_idle.
2. Read burst, s_addr = 0xFE, s_bcnt = 2, m_busy toggling every other cycle -> m_rreq accesses taken at 0xFE, 0xFF, 0x00 (wrap); s_busy = 1 until the 3rd access; slave data is echoed on s_rval/s_rdat in order.
3. Single-beat write, s_bcnt = 0 -> exactly one m_wreq at s_addr and the FSM never enters st_write; an immediately following s_rreq is accepted the next cycle.
4. Simultaneous s_wreq and s_rreq in st_idle with s_bcnt = 1 -> the write is taken first and m_rreq stays 0; the read is issued after the 2nd write beat.
5. Reset asserted mid-read after 2 of 8 beats -> m_rreq = 0 and s_busy = 0 asynchronously; the next burst starts at its own s_addr.
6. With MMB_TO_MMV_WTIMEOUT_EN and WTIMEOUT = 4: s_bcnt = 3, then 1 beat followed by 4 idle cycles -> return to st_idle; the next s_wreq uses its own s_addr as the start address.
